// File: rtl/csa_pipelined_adder.sv
// csa_pipelined_adder: pipelined carry-skip adder/subtractor, one skip group per stage
// Stage k adds group k and forwards the untouched upper operand bits to stage k+1.
module csa_pipelined_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N = WIDTH / BLOCK;
    if (WIDTH % BLOCK != 0) begin : g_bad_cfg
        $error("csa_pipelined_adder: WIDTH must be a multiple of BLOCK");
    end
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    for (genvar k = 0; k < N; k++) begin : g_st
        localparam int IW = WIDTH - k * BLOCK;
        localparam int SW = (k + 1) * BLOCK;
        logic [IW-1:0]    ai, bi;
        logic             ci, vi, rc, cn, v_q, c_q;
        logic [BLOCK-1:0] gs;
        logic [SW-1:0]    s_n, s_q;
        if (k == 0) begin : g_in
            assign ai  = a;
            assign bi  = sub ? ~b : b;
            assign ci  = sub | cin;
            assign vi  = in_valid;
            assign s_n = gs;
        end else begin : g_in
            assign ai  = g_st[k-1].g_fw.a_q;
            assign bi  = g_st[k-1].g_fw.b_q;
            assign ci  = g_st[k-1].c_q;
            assign vi  = g_st[k-1].v_q;
            assign s_n = {gs, g_st[k-1].s_q};
        end
        assign {rc, gs} = {1'b0, ai[BLOCK-1:0]} + {1'b0, bi[BLOCK-1:0]} + {{BLOCK{1'b0}}, ci};
        // skip mux: an all-propagate group passes its incoming carry straight through
        assign cn = &(ai[BLOCK-1:0] ^ bi[BLOCK-1:0]) ? ci : rc;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (en) begin
                v_q <= vi;
                c_q <= cn;
                s_q <= s_n;
            end
        end
        if (IW > BLOCK) begin : g_fw
            logic [IW-BLOCK-1:0] a_q, b_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= ai[IW-1:BLOCK];
                    b_q <= bi[IW-1:BLOCK];
                end
            end
        end
        if (k == N - 1) begin : g_ovf
            logic o_q;
            // carry into the MSB is recovered from the MSB operand and sum bits
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    o_q <= 1'b0;
                else if (en)
                    o_q <= ai[BLOCK-1] ^ bi[BLOCK-1] ^ gs[BLOCK-1] ^ cn;
            end
        end
    end
    assign out_valid = g_st[N-1].v_q;
    assign sum       = g_st[N-1].s_q;
    assign cout      = g_st[N-1].c_q;
    assign ovf       = g_st[N-1].g_ovf.o_q;
endmodule

// File: tb/tb_csa_pipelined_adder.sv
// tb_csa_pipelined_adder: directed and random checks of three adder configurations
// against a queue-based arithmetic model with per-entry age in enabled edges.
module tb_csa_pipelined_adder;
    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        int          age;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv [3], ordy [3], cin_s [3], sub_s [3];
    logic        irdy [3], ov [3], co [3], of [3];
    logic [31:0] av [3], bv [3];
    logic [31:0] s0, s2;
    logic [15:0] s1;
    int          checks = 0;
    int          errors = 0;
    ent_t        q [3][$];
    bit          skip = 1'b1;

    always #5 clk = ~clk;

    csa_pipelined_adder #(.WIDTH(32), .BLOCK(8)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]), .a(av[0]), .b(bv[0]),
        .cin(cin_s[0]), .sub(sub_s[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s0),
        .cout(co[0]), .ovf(of[0]));
    csa_pipelined_adder #(.WIDTH(16), .BLOCK(4)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]), .a(av[1][15:0]),
        .b(bv[1][15:0]), .cin(cin_s[1]), .sub(sub_s[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .sum(s1), .cout(co[1]), .ovf(of[1]));
    csa_pipelined_adder #(.WIDTH(32), .BLOCK(32)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]), .a(av[2]), .b(bv[2]),
        .cin(cin_s[2]), .sub(sub_s[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s2),
        .cout(co[2]), .ovf(of[2]));

    function automatic int wof(input int i);
        return i == 1 ? 16 : 32;
    endfunction

    function automatic int nof(input int i);
        return i == 2 ? 1 : 4;
    endfunction

    function automatic logic [31:0] maskof(input int i);
        return i == 1 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] sumof(input int i);
        return i == 0 ? s0 : i == 1 ? {16'd0, s1} : s2;
    endfunction

    // {ovf, cout, sum}: plain w-bit two's-complement arithmetic
    function automatic logic [33:0] calc(input logic [31:0] a, b, input logic cin, sub, input int w);
        logic [31:0] m, bb, s;
        logic [32:0] t;
        logic        o;
        m  = w == 32 ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
        bb = (sub ? ~b : b) & m;
        t  = {1'b0, a & m} + {1'b0, bb} + {32'd0, sub | cin};
        s  = t[31:0] & m;
        o  = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
        return {o, t[w], s};
    endfunction

    task automatic chk(input string nm, input logic [33:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_edge(input int i);
        logic [33:0] r;
        bit          vis;
        ent_t        e;
        vis = q[i].size() > 0 && q[i][0].age == nof(i);
        if (vis && !ordy[i]) return;
        if (vis) void'(q[i].pop_front());
        for (int j = 0; j < q[i].size(); j++) q[i][j].age = q[i][j].age + 1;
        if (iv[i]) begin
            r = calc(av[i], bv[i], cin_s[i], sub_s[i], wof(i));
            e.s = r[31:0];
            e.c = r[32];
            e.o = r[33];
            e.age = 1;
            q[i].push_back(e);
        end
    endtask

    task automatic cmp(input int i);
        bit vis;
        vis = q[i].size() > 0 && q[i][0].age == nof(i);
        chk($sformatf("u%0d out_valid", i), ov[i], vis);
        chk($sformatf("u%0d in_ready", i), irdy[i], !vis || ordy[i]);
        if (vis) begin
            chk($sformatf("u%0d sum", i), sumof(i), q[i][0].s);
            chk($sformatf("u%0d cout", i), co[i], q[i][0].c);
            chk($sformatf("u%0d ovf", i), of[i], q[i][0].o);
        end
    endtask

    // the compare process: replay the edge just past into the model, then check every output
    initial forever begin
        @(negedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) q[i].delete();
            skip = 1'b1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!skip) model_edge(i);
                cmp(i);
            end
            skip = 1'b0;
        end
    end

    task automatic go();
        @(negedge clk);
        #1;
    endtask

    task automatic op0(input string nm, input logic [31:0] a, b, input logic cin, sub,
                       input logic [31:0] es, input logic ec, eo);
        iv[0] = 1'b1; av[0] = a; bv[0] = b; cin_s[0] = cin; sub_s[0] = sub;
        go();
        iv[0] = 1'b0;
        go();
        go();
        chk({nm, " early"}, ov[0], 1'b0);
        go();
        chk({nm, " valid"}, ov[0], 1'b1);
        chk({nm, " sum"}, s0, es);
        chk({nm, " cout"}, co[0], ec);
        chk({nm, " ovf"}, of[0], eo);
    endtask

    initial begin
        int  stall;
        bit  taken [3];
        int  cnt [3];
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b1; av[i] = '0; bv[i] = '0; cin_s[i] = 1'b0; sub_s[i] = 1'b0;
            taken[i] = 1'b0; cnt[i] = 0;
        end
        chk("model add ovf", calc(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32), {2'b10, 32'h8000_0000});
        chk("model sub16", calc(32'h0005, 32'h0007, 1'b1, 1'b1, 16), {2'b00, 32'h0000_FFFE});
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", ov[0], 1'b0);
        chk("reset sum", s0, 32'h0);
        chk("reset cout", co[0], 1'b0);
        chk("reset ovf", of[0], 1'b0);
        rst_n = 1'b1;
        #1;
        chk("in_ready after reset", irdy[0], 1'b1);
        go();
        op0("t1 skip chain", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        op0("t2 add ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        op0("t3 sub borrow", 32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        op0("t3 sub ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        go();
        ordy[0] = 1'b0;
        stall = 0;
        for (int i = 1; i <= 6; i++) begin
            iv[0] = 1'b1; av[0] = i; bv[0] = i; cin_s[0] = 1'b0; sub_s[0] = 1'b0;
            #1;
            if (i == 5) chk("t4 stalled in_ready", irdy[0], 1'b0);
            while (!irdy[0] && stall < 20) begin
                chk("t4 held valid", ov[0], 1'b1);
                chk("t4 held sum", s0, 32'd2);
                stall++;
                if (stall == 3) begin
                    ordy[0] = 1'b1;
                    #1;
                end else go();
            end
            if (stall >= 20) chk("t4 stall timeout", irdy[0], 1'b1);
            go();
        end
        iv[0] = 1'b0;
        for (int v = 6; v <= 12; v += 2) begin
            chk($sformatf("t4 result %0d", v), {ov[0], s0}, {1'b1, 32'(v)});
            go();
        end
        chk("t4 drained", ov[0], 1'b0);
        for (int i = 0; i < 3; i++) begin
            iv[0] = 1'b1; av[0] = 32'd10 + i; bv[0] = 32'd1;
            go();
        end
        iv[0] = 1'b0;
        go();
        chk("t5 in flight", ov[0], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5 async out_valid", ov[0], 1'b0);
        chk("t5 async sum", s0, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) begin
            go();
            chk("t5 no stale", ov[0], 1'b0);
        end
        op0("t5 after reset", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);
        for (int cyc = 0; cyc < 40000 && (cnt[1] < 10000 || cnt[2] < 10000); cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if (!iv[i] || taken[i]) begin
                    iv[i]    = $urandom_range(3) != 0;
                    av[i]    = $urandom & maskof(i);
                    bv[i]    = $urandom_range(3) == 0 ? ~av[i] & maskof(i) : $urandom & maskof(i);
                    cin_s[i] = $urandom_range(1) == 1;
                    sub_s[i] = $urandom_range(1) == 1;
                end
                ordy[i] = $urandom_range(3) != 0;
            end
            #1;
            for (int i = 0; i < 3; i++) begin
                taken[i] = iv[i] && irdy[i];
                if (taken[i]) cnt[i]++;
            end
            go();
        end
        chk("u1 random count", cnt[1] >= 10000, 1'b1);
        chk("u2 random count", cnt[2] >= 10000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0;
            ordy[i] = 1'b1;
        end
        repeat (8) go();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
